// File: rtl/r5p_ifu_pfb.sv
// Instruction fetch unit with a DEPTH-word prefetch queue and 16/32-bit realignment.
// Streams aligned program-bus words and hands one instruction per cycle to decode.
module r5p_ifu_pfb #(
    parameter int unsigned    IAW   = 32,
    parameter int unsigned    IDW   = 32,
    parameter int unsigned    DEPTH = 4,
    parameter bit             CFG_C = 1'b1,
    parameter logic [IAW-1:0] PC0   = '0
)(
    input  logic           clk,
    input  logic           rst_n,
    output logic           if_vld,
    output logic [IAW-1:0] if_adr,
    input  logic [IDW-1:0] if_rdt,
    input  logic           if_rdy,
    output logic           id_vld,
    input  logic           id_rdy,
    output logic [31:0]    id_ins,
    output logic [2:0]     id_siz,
    output logic [IAW-1:0] id_pc,
    input  logic           jmp_vld,
    input  logic [IAW-1:0] jmp_adr
);

    localparam int unsigned HW  = IDW/16;
    localparam int unsigned OFW = $clog2(HW);
    localparam int unsigned BW  = $clog2(IDW/8);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + OFW + 2;

    // Without the C extension the halfword index only moves in steps of two.
    localparam logic [OFW-1:0] OFF_MSK = {OFW{1'b1}} ^ OFW'(!CFG_C);
    localparam logic [IAW-1:0] PC0_AL  = {PC0[IAW-1:BW], {BW{1'b0}}};
    localparam logic [OFW-1:0] PC0_OFF = PC0[OFW:1] & OFF_MSK;
    localparam logic [IAW-1:0] PC0_PC  = {PC0[IAW-1:2], PC0[1] & CFG_C, 1'b0};

    logic [IDW-1:0] q [DEPTH];
    logic [AW-1:0]  hd, tl;
    logic [AW:0]    cnt;
    logic [OFW-1:0] off;
    logic [IAW-1:0] fptr, pc;
    logic           run, out;

    logic [IAW-1:0] jmp_al, jmp_pc;
    logic [OFW-1:0] jmp_off;
    logic [2*IDW-1:0] win;
    logic [OFW+4:0] lo_b, hi_b;
    logic [15:0]    hw_lo, hw_hi;
    logic           comp, enough, fire_if, fire_id, push, pop;
    logic [CW-1:0]  avail, need;
    logic [OFW:0]   off_nx;
    logic [AW+1:0]  occ;

    assign jmp_al  = {jmp_adr[IAW-1:BW], {BW{1'b0}}};
    assign jmp_off = jmp_adr[OFW:1] & OFF_MSK;
    assign jmp_pc  = {jmp_adr[IAW-1:2], jmp_adr[1] & CFG_C, jmp_adr[0] & 1'b0};

    // Two-word window so a 32-bit instruction may straddle head and head+1.
    assign win   = {q[hd + AW'(1)], q[hd]};
    assign lo_b  = {1'b0, off, 4'b0000};
    assign hi_b  = lo_b + (OFW+5)'(16);
    assign hw_lo = win[lo_b +: 16];
    assign hw_hi = win[hi_b +: 16];

    assign comp   = CFG_C && (hw_lo[1:0] != 2'b11);
    assign avail  = {1'b0, cnt, {OFW{1'b0}}} - CW'(off);
    assign need   = comp ? CW'(1) : CW'(2);
    assign enough = (cnt != '0) && (avail >= need);

    assign id_vld = ~jmp_vld & enough;
    assign id_ins = (cnt == '0) ? 32'h0 : comp ? {16'h0, hw_lo} : {hw_hi, hw_lo};
    assign id_siz = ((cnt != '0) && comp) ? 3'd2 : 3'd4;
    assign id_pc  = pc;

    // A pop in the current cycle is deliberately not credited to the request.
    assign occ    = {1'b0, cnt} + (AW+2)'(out);
    assign if_vld = run & ~jmp_vld & (occ < (AW+2)'(DEPTH));
    assign if_adr = fptr;

    assign fire_if = if_vld & if_rdy;
    assign fire_id = id_vld & id_rdy;
    assign off_nx  = {1'b0, off} + (comp ? (OFW+1)'(1) : (OFW+1)'(2));
    assign push    = out & ~jmp_vld;
    assign pop     = fire_id & off_nx[OFW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run  <= 1'b0;
            out  <= 1'b0;
            hd   <= '0;
            tl   <= '0;
            cnt  <= '0;
            off  <= PC0_OFF;
            fptr <= PC0_AL;
            pc   <= PC0_PC;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            run <= 1'b1;
            if (jmp_vld) begin
                out  <= 1'b0;
                hd   <= '0;
                tl   <= '0;
                cnt  <= '0;
                off  <= jmp_off;
                fptr <= jmp_al;
                pc   <= jmp_pc;
            end else begin
                out <= fire_if;
                if (fire_if) fptr <= fptr + IAW'(IDW/8);
                if (push) begin
                    q[tl] <= if_rdt;
                    tl    <= tl + AW'(1);
                end
                if (fire_id) begin
                    off <= off_nx[OFW-1:0];
                    pc  <= pc + {{(IAW-3){1'b0}}, id_siz};
                    if (pop) hd <= hd + AW'(1);
                end
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

endmodule

// File: tb/tb_r5p_ifu_pfb.sv
// Directed and randomized bench for r5p_ifu_pfb against a program-memory
// reference: expected instructions are decoded straight from halfwords at the PC.
module tb_r5p_ifu_pfb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_vld, if_rdy, id_vld, id_rdy, jmp_vld;
    logic [31:0] if_adr, if_rdt, id_ins, id_pc, jmp_adr;
    logic [2:0]  id_siz;

    logic [31:0] mem [256];
    logic [31:0] rsp_adr = 32'h0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    r5p_ifu_pfb #(
        .IAW(32), .IDW(32), .DEPTH(4), .CFG_C(1'b1), .PC0(32'h100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_vld(if_vld), .if_adr(if_adr), .if_rdt(if_rdt), .if_rdy(if_rdy),
        .id_vld(id_vld), .id_rdy(id_rdy), .id_ins(id_ins), .id_siz(id_siz),
        .id_pc(id_pc), .jmp_vld(jmp_vld), .jmp_adr(jmp_adr)
    );

    // Program bus slave: data for an accepted address appears the next cycle.
    always @(posedge clk) if (if_vld && if_rdy) rsp_adr <= if_adr;
    assign if_rdt = mem[rsp_adr[9:2]];

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] ins_at(input logic [31:0] a);
        logic [15:0] h;
        h = hw_at(a);
        if (h[1:0] != 2'b11) return {16'h0, h};
        return {hw_at(a + 32'd2), h};
    endfunction

    function automatic logic [31:0] siz_at(input logic [31:0] a);
        logic [15:0] h;
        h = hw_at(a);
        return (h[1:0] != 2'b11) ? 32'd2 : 32'd4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [31:0] a);
        jmp_vld = 1'b1;
        jmp_adr = a;
        #1;
        chk("jmp_id_vld", id_vld, 0);
        chk("jmp_if_vld", if_vld, 0);
        step;
        jmp_vld = 1'b0;
        #1;
    endtask

    // Wait (bounded) for the next instruction, check it, consume it.
    task automatic expect_ins(input logic [31:0] pc);
        int w;
        w = 0;
        id_rdy = 1'b1;
        #1;
        while (!id_vld && w < 30) begin
            step;
            w++;
        end
        chk("id_vld_wait", id_vld, 1);
        chk("id_pc", id_pc, pc);
        chk("id_ins", id_ins, ins_at(pc));
        chk("id_siz", 32'(id_siz), siz_at(pc));
        step;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, idle;
        logic [31:0] m_pc, m_fa, e_siz;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 8; i++) mem[64 + i] = 32'h0000_0013;
        for (int i = 0; i < 8; i++) mem[192 + i] = (32'(i) << 20) | 32'h13;
        mem[0]   = 32'h0001_4501;
        mem[1]   = 32'h0000_0013;
        mem[16]  = 32'h0013_4501;
        mem[17]  = 32'h0000_0000;
        mem[128] = 32'h4505_0013;
        mem[129] = 32'h0000_0013;

        if_rdy = 1'b1; id_rdy = 1'b0; jmp_vld = 1'b0; jmp_adr = 32'h0;

        // Reset values and start-up latency
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_vld", if_vld, 0);
        chk("rst_id_vld", id_vld, 0);
        chk("rst_id_pc", id_pc, 32'h100);
        chk("rst_id_ins", id_ins, 32'h0);
        chk("rst_id_siz", 32'(id_siz), 32'd4);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("run0_if_vld", if_vld, 0);
        for (int i = 0; i < 4; i++) begin
            chk("first_id_vld", id_vld, 32'(i == 3));
            if (i == 1) chk("if_adr_0", if_adr, 32'h100);
            if (i == 2) chk("if_adr_1", if_adr, 32'h104);
            if (i < 3) step;
        end
        expect_ins(32'h100);
        expect_ins(32'h104);
        expect_ins(32'h108);
        id_rdy = 1'b0;

        // Decode stalled: queue fills with exactly DEPTH fetches
        jump(32'h300);
        nf = 0;
        for (int i = 0; i < 10; i++) begin
            if (if_vld && if_rdy) nf++;
            step;
        end
        chk("stall_fetches", 32'(nf), 32'd4);
        chk("stall_if_vld", if_vld, 0);
        chk("stall_id_vld", id_vld, 1);
        chk("stall_id_ins", id_ins, ins_at(32'h300));
        id_rdy = 1'b1;
        #1;
        chk("resume_id_pc", id_pc, 32'h300);
        step;
        id_rdy = 1'b0;
        #1;
        chk("resume_if_vld", if_vld, 1);
        chk("resume_if_adr", if_adr, 32'h310);
        step;
        chk("one_per_pop", if_vld, 0);

        // Compressed instructions
        jump(32'h0);
        expect_ins(32'h0);
        expect_ins(32'h2);
        expect_ins(32'h4);
        id_rdy = 1'b0;

        // Straddling 32-bit instruction with its second half delayed
        jump(32'h40);
        chk("strad_if_adr", if_adr, 32'h40);
        step;
        if_rdy = 1'b0;
        #1;
        expect_ins(32'h40);
        for (int i = 0; i < 5; i++) begin
            chk("strad_hold_vld", id_vld, 0);
            chk("strad_hold_pc", id_pc, 32'h42);
            step;
        end
        if_rdy = 1'b1;
        expect_ins(32'h42);
        id_rdy = 1'b0;

        // Redirect to odd halfword while a response is arriving
        jump(32'h300);
        step;
        jump(32'h202);
        chk("redir_if_vld", if_vld, 1);
        chk("redir_if_adr", if_adr, 32'h200);
        expect_ins(32'h202);
        expect_ins(32'h204);
        id_rdy = 1'b0;

        // Reset with a fetch outstanding
        jump(32'h300);
        step;
        rst_n = 1'b0;
        #1;
        chk("mrst_if_vld", if_vld, 0);
        chk("mrst_id_vld", id_vld, 0);
        chk("mrst_id_pc", id_pc, 32'h100);
        step;
        rst_n = 1'b1;
        expect_ins(32'h100);
        expect_ins(32'h104);

        // Randomized traffic against the program-memory model
        m_pc = 32'h0;
        m_fa = 32'h0;
        idle = 0;
        for (int n = 0; n < 3000; n++) begin
            if_rdy  = ($urandom_range(0, 3) != 0);
            id_rdy  = ($urandom_range(0, 2) != 0);
            jmp_vld = (n == 0) || ($urandom_range(0, 39) == 0);
            if (jmp_vld) jmp_adr = 32'($urandom_range(0, 1023));
            #1;
            if (jmp_vld) begin
                chk("rnd_jmp_id_vld", id_vld, 0);
                chk("rnd_jmp_if_vld", if_vld, 0);
                m_pc = jmp_adr & ~32'h1;
                m_fa = jmp_adr & ~32'h3;
                idle = 0;
            end else begin
                if (if_vld && if_rdy) begin
                    chk("rnd_if_adr", if_adr, m_fa);
                    m_fa = m_fa + 32'd4;
                end
                if (id_vld && id_rdy) begin
                    e_siz = siz_at(m_pc);
                    chk("rnd_id_pc", id_pc, m_pc);
                    chk("rnd_id_ins", id_ins, ins_at(m_pc));
                    chk("rnd_id_siz", 32'(id_siz), e_siz);
                    m_pc = m_pc + e_siz;
                    idle = 0;
                end else begin
                    idle++;
                end
                if (idle > 60) begin
                    chk("rnd_progress", 32'(idle), 32'd0);
                    idle = 0;
                end
            end
            step;
        end
        jmp_vld = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
